col_rr_arbiter: RTL

Shares one downstream column-processing resource (the sub1/sub2 datapath) between COLS requesting columns. Each column presents a valid/data pair. The block buffers one beat per column, picks a winner by round-robin, and issues one beat per cycle to the resource. Issue is flow-controlled by a credit counter that the resource replenishes with return pulses. The block sits between the per-column ival/idata inputs of top and the shared datapath.

---
 rtl/col_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 36 +++
 rtl/col_rr_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/col_arb_pkg.sv
// Shared types and width helpers for the column round-robin arbiter and its picker.
// Typedefs describe the default configuration; instances size themselves from parameters.
package col_arb_pkg;

  localparam int unsigned COLS_DEF    = 4;
  localparam int unsigned CREDITS_DEF = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned crd_w(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  typedef logic [idx_w(COLS_DEF)-1:0]    col_idx_t;
  typedef logic [crd_w(CREDITS_DEF)-1:0] crd_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
// Rotates a doubled request vector so the search always starts at bit 0.
module rr_pick
  import col_arb_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0]          req,
  input  logic [idx_w(COLS)-1:0]   ptr,
  output logic                     gnt_vld,
  output logic [idx_w(COLS)-1:0]   gnt_idx
);

  localparam int IW = idx_w(COLS);

  logic [2*COLS-1:0] dbl;
  logic [COLS-1:0]   rot;
  int                start;
  int                off;
  int                sum;

  always_comb begin
    start   = int'(ptr) + 1;
    dbl     = {req, req} >> start;
    rot     = dbl[COLS-1:0];
    gnt_vld = |req;
    off     = 0;
    for (int k = COLS - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = start + off;
    if (sum >= COLS) sum = sum - COLS;
    gnt_idx = IW'(sum);
  end

endmodule

// File: rtl/col_rr_arbiter.sv
// Shares one downstream column resource among COLS requesters: one-beat holding slot
// per column, round-robin grant, credit-limited issue of one beat per cycle.
module col_rr_arbiter
  import col_arb_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int DW      = 2,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [COLS-1:0]          ival,
  input  logic [COLS-1:0][DW-1:0]  idata,
  output logic [COLS-1:0]          irdy,
  output logic                     oval,
  output logic [DW-1:0]            odata,
  output logic [idx_w(COLS)-1:0]   ocol,
  input  logic                     crd_ret,
  output logic                     busy,
  output logic                     err_ovf
);

  localparam int            IW       = idx_w(COLS);
  localparam int            CW       = crd_w(CREDITS);
  localparam logic [CW-1:0] CRD_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] CRD_ONE  = CW'(1);

  logic [COLS-1:0]         held_p0;
  logic [COLS-1:0][DW-1:0] slot_data_p0;
  logic [IW-1:0]           ptr;
  logic [CW-1:0]           crd_cnt;
  logic                    req_vld;
  logic [IW-1:0]           win_idx;
  logic                    gnt;
  logic [COLS-1:0]         accept;

  rr_pick #(
    .COLS (COLS)
  ) u_pick (
    .req     (held_p0),
    .ptr     (ptr),
    .gnt_vld (req_vld),
    .gnt_idx (win_idx)
  );

  assign gnt    = req_vld && (crd_cnt != '0);
  assign accept = ival & ~held_p0;
  assign irdy   = ~held_p0;
  assign busy   = (|held_p0) || (crd_cnt != CRD_FULL);

  // Stage p0: per-column holding slots (slot refills no earlier than the cycle after its grant)
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      held_p0 <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (gnt && (win_idx == IW'(c))) held_p0[c] <= 1'b0;
        else if (accept[c])             held_p0[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (accept[c]) slot_data_p0[c] <= idata[c];
    end
  end

  // Arbitration state: pointer and credit counter; a return at zero credits only enables next cycle
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ptr     <= IW'(COLS - 1);
      crd_cnt <= CRD_FULL;
      err_ovf <= 1'b0;
    end else begin
      if (gnt) ptr <= win_idx;
      case ({gnt, crd_ret})
        2'b10: crd_cnt <= crd_cnt - CRD_ONE;
        2'b01: begin
          if (crd_cnt == CRD_FULL) err_ovf <= 1'b1;
          else                     crd_cnt <= crd_cnt + CRD_ONE;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: issue register toward the shared resource
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      oval  <= 1'b0;
      odata <= '0;
      ocol  <= '0;
    end else begin
      oval <= gnt;
      if (gnt) begin
        odata <= slot_data_p0[win_idx];
        ocol  <= win_idx;
      end
    end
  end

endmodule
